// File: rtl/pot_pkg.sv
// Shared types and weight-field helpers for the power-of-two shift accumulator.
// Holds the FSM state enum and the widths derived from the sign+exponent weight format.
package pot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pot_state_e;

  // The weight MSB is the sign; every bit below it belongs to the exponent.
  function automatic int pot_sign_idx(input int weight_w);
    return weight_w - 1;
  endfunction

  function automatic int pot_exp_width(input int weight_w);
    return weight_w - 1;
  endfunction

  // Width of in * 2^exp with the largest exponent the field can encode.
  function automatic int pot_mag_width(input int in_w, input int exp_w);
    return in_w + (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/unsigned_pot_shift.sv
// Unsigned power-of-two product: in_i shifted left by exp_i.
// The output is wide enough to hold the largest exponent without loss.
module unsigned_pot_shift
  import pot_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int EXP_W = 3
) (
  input  logic [IN_W-1:0]                        in_i,
  input  logic [EXP_W-1:0]                       exp_i,
  output logic [pot_mag_width(IN_W, EXP_W)-1:0]  prod_o
);

  localparam int OUT_W = pot_mag_width(IN_W, EXP_W);

  assign prod_o = OUT_W'(in_i) << exp_i;

endmodule

// File: rtl/pot_shift_accumulator.sv
// Dot product of unsigned activations with sign+exponent weights, one beat per accepted pair.
// Define POT_ACC_SATURATE_EN to clamp each addition; otherwise additions wrap in two's complement.
module pot_shift_accumulator
  import pot_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int ACC_BIT_WIDTH    = 16,
  parameter int NUM_TERMS        = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INPUT_BIT_WIDTH-1:0]       in,
  input  logic [WEIGHT_BIT_WIDTH-1:0]      weight,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [ACC_BIT_WIDTH-1:0]  out
);

  localparam int EXP_W    = pot_exp_width(WEIGHT_BIT_WIDTH);
  localparam int SIGN_IDX = pot_sign_idx(WEIGHT_BIT_WIDTH);
  localparam int MAG_W    = pot_mag_width(INPUT_BIT_WIDTH, EXP_W);
  localparam int PROD_W   = MAG_W + 1;
  localparam int ACC_W    = ACC_BIT_WIDTH;
  localparam int CNT_W    = $clog2(NUM_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  pot_state_e               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ready_en_q;

  logic [MAG_W-1:0]         mag;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [ACC_W-1:0]  prod_acc;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  sum_acc;
  logic                     accept;

  unsigned_pot_shift #(
    .IN_W  (INPUT_BIT_WIDTH),
    .EXP_W (EXP_W)
  ) u_shift (
    .in_i   (in),
    .exp_i  (weight[EXP_W-1:0]),
    .prod_o (mag)
  );

  // Negating a zero magnitude yields zero, so a negative weight on in=0 adds nothing.
  assign prod_full = weight[SIGN_IDX] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

  generate
    if (PROD_W >= ACC_W) begin : g_prod_trunc
      assign prod_acc = prod_full[ACC_W-1:0];
    end else begin : g_prod_sext
      assign prod_acc = {{(ACC_W-PROD_W){prod_full[PROD_W-1]}}, prod_full};
    end
  endgenerate

  // The first beat of a dot product loads the product, so it adds onto zero.
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;

`ifdef POT_ACC_SATURATE_EN
  logic signed [ACC_W:0] sum_wide;

  assign sum_wide = {acc_base[ACC_W-1], acc_base} + {prod_acc[ACC_W-1], prod_acc};

  always_comb begin
    sum_acc = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sum_acc = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum_acc = acc_base + prod_acc;
`endif

  assign accept    = in_valid && in_ready;
  assign in_ready  = ready_en_q && (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out       = acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = sum_acc;
          cnt_d = CNT_W'(1);
          if (NUM_TERMS == 1) begin
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = sum_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

endmodule
